// File: rtl/div_unit_pkg.sv
// Shared types for the execute-stage divider.
//   bus_type       - 32-bit register operand / result word
//   div_op_type    - DIV, DIVU, REM, REMU
//   div_state_type - divider FSM states IDLE, CALC, DONE
//   DIV_ITERATIONS - restoring steps per operation (one per quotient bit)
package types;

    typedef logic [31:0] bus_type;

    typedef enum logic [1:0] {
        DIV,
        DIVU,
        REM,
        REMU
    } div_op_type;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_type;

    localparam int unsigned DIV_ITERATIONS = 32;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between decode/execute and the divider.
//   start  - request, sampled only when the divider can accept
//   op     - DIV / DIVU / REM / REMU, sampled with start
//   a, b   - dividend and divisor, sampled with start
//   busy   - divider holds an operation
//   done   - one-cycle pulse, result valid while high
//   result - quotient or remainder
// master: requester side, slave: divider side.
interface div_unit_if;
    import types::*;

    logic       start;
    div_op_type op;
    bus_type    a;
    bus_type    b;
    logic       busy;
    logic       done;
    bus_type    result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration.
//   rem_in  - 33-bit partial remainder
//   quo_in  - quotient register (unconsumed dividend bits shift out of the top)
//   dvs     - 33-bit divisor magnitude
//   rem_out - next partial remainder
//   quo_out - next quotient register, new quotient bit in the LSB
module div_step
    import types::*;
(
    input  logic [32:0] rem_in,
    input  bus_type     quo_in,
    input  logic [32:0] dvs,
    output logic [32:0] rem_out,
    output bus_type     quo_out
);

    logic [33:0] rem_sh;
    logic [33:0] diff;

    always_comb begin
        rem_sh = {rem_in, quo_in[31]};
        // One guard bit above the 33-bit values makes the sign of the trial
        // subtraction unambiguous.
        diff   = rem_sh - {1'b0, dvs};
        if (!diff[33]) begin
            rem_out = diff[32:0];
            quo_out = {quo_in[30:0], 1'b1};
        end else begin
            rem_out = rem_sh[32:0];
            quo_out = {quo_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - div_unit_if.slave: start/op/a/b in, busy/done/result out
// One restoring step per CALC cycle; the final CALC edge applies the sign
// fix-up and special cases, giving done 33 edges after the accept edge.
// Build option: DIV_EARLY_OUT_EN - divide-by-zero and signed overflow go
// straight to DONE, so done appears in the cycle after the accept edge.
module div_unit
    import types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    div_unit_if.slave   bus
);

    div_state_type state;
    logic [4:0]    cnt;
    logic          fin;       // all iterations done, next CALC edge finalises
    logic [32:0]   rem_q;
    bus_type       quo_q;
    logic [32:0]   dvs_q;
    div_op_type    op_q;
    logic          qneg_q;
    logic          rneg_q;
    logic          dz_q;
    logic          ovf_q;
    bus_type       a_q;       // original dividend, returned by REM on /0
    logic          busy_q;
    logic          done_q;
    bus_type       result_q;

    logic          is_signed;
    logic          dz_in;
    logic          ovf_in;
    bus_type       a_mag;
    logic [32:0]   b_mag;
    logic [32:0]   rem_nx;
    bus_type       quo_nx;
    bus_type       fin_val;

    function automatic bus_type special_res(div_op_type o, logic dz, bus_type a_orig);
        logic is_quo;
        is_quo = (o == DIV) || (o == DIVU);
        if (dz)
            special_res = is_quo ? 32'hFFFF_FFFF : a_orig;
        else
            special_res = is_quo ? 32'h8000_0000 : 32'h0000_0000;
    endfunction

    always_comb begin
        is_signed = (bus.op == DIV) || (bus.op == REM);
        dz_in     = (bus.b == '0);
        ovf_in    = is_signed && (bus.a == 32'h8000_0000) && (bus.b == '1);
        a_mag     = (is_signed && bus.a[31]) ? 32'd0 - bus.a : bus.a;
        b_mag     = (is_signed && bus.b[31]) ? 33'd0 - {bus.b[31], bus.b}
                                             : {1'b0, bus.b};
    end

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dvs     (dvs_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_comb begin
        if (dz_q || ovf_q)
            fin_val = special_res(op_q, dz_q, a_q);
        else if ((op_q == DIV) || (op_q == DIVU))
            fin_val = qneg_q ? 32'd0 - quo_q : quo_q;
        else
            fin_val = bus_type'(rneg_q ? 33'd0 - rem_q : rem_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            fin      <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_q     <= DIV;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                // The DONE->IDLE edge also accepts a waiting request, which
                // keeps back-to-back operations 34 cycles apart with busy held.
                IDLE, DONE: begin
                    if (bus.start) begin
                        rem_q  <= '0;
                        quo_q  <= a_mag;
                        dvs_q  <= b_mag;
                        op_q   <= bus.op;
                        qneg_q <= is_signed && (bus.a[31] ^ bus.b[31]);
                        rneg_q <= is_signed && bus.a[31];
                        dz_q   <= dz_in;
                        ovf_q  <= ovf_in;
                        a_q    <= bus.a;
                        cnt    <= '0;
                        fin    <= 1'b0;
                        busy_q <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        if (dz_in || ovf_in) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_res(bus.op, dz_in, bus.a);
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                CALC: begin
                    if (!fin) begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt == 5'(DIV_ITERATIONS - 1))
                            fin <= 1'b1;
                        else
                            cnt <= cnt + 5'd1;
                    end else begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        result_q <= fin_val;
                        cnt      <= '0;
                        fin      <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    import types::*;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    div_unit_if bus ();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M reference semantics in plain integer arithmetic.
    function automatic bus_type ref_div(div_op_type op, bus_type a, bus_type b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            DIVU:    ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU:    ref_div = (b == 0) ? a : a % b;
            DIV:     ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : bus_type'(sa / sb);
            default: ref_div = (b == 0) ? a : ovf ? 32'h0 : bus_type'(sa % sb);
        endcase
    endfunction

    function automatic int unsigned ref_lat(div_op_type op, bus_type a, bus_type b);
        logic sgn;
        sgn = (op == DIV) || (op == REM);
        if (EARLY && ((b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            ref_lat = 0;
        else
            ref_lat = 33;
    endfunction

    // Issues one request, measures edges from accept edge to done, checks
    // result, busy across the operation, and the idle state afterwards.
    task automatic run_op(input div_op_type op, input bus_type a, input bus_type b);
        bus_type     exp;
        int unsigned lat;
        logic        busy_ok;
        exp = ref_div(op, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check($sformatf("busy_rise %s", op.name()), 32'(bus.busy), 32'd1);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        check($sformatf("latency %s %h/%h", op.name(), a, b), lat, ref_lat(op, a, b));
        check($sformatf("result %s %h/%h", op.name(), a, b), bus.result, exp);
        check("busy_hold", 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1;
        check("done_fall", 32'(bus.done), 32'd0);
        check("busy_fall", 32'(bus.busy), 32'd0);
        check("result_hold", bus.result, exp);
    endtask

    initial begin
        int unsigned lat;
        logic        busy_ok;
        div_op_type  rop;
        bus_type     ra;
        bus_type     rb;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = DIVU;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(DIVU, 32'd100, 32'd7);
        run_op(REMU, 32'd100, 32'd7);
        run_op(DIV,  32'hFFFF_FF9C, 32'd7);
        run_op(REM,  32'hFFFF_FF9C, 32'd7);
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op(DIVU, 32'h0000_1234, 32'd0);
        run_op(REMU, 32'h0000_1234, 32'd0);
        run_op(DIV,  32'hFFFF_FF9C, 32'd0);
        run_op(REM,  32'hFFFF_FF9C, 32'd0);
        run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(DIV,  32'h8000_0000, 32'd1);
        run_op(REM,  32'd7, 32'hFFFF_FFFD);

        // start held high: second request is taken on the DONE->IDLE edge
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd10;
        @(posedge clk);
        #1;
        lat     = 0;
        busy_ok = bus.busy;
        while (!bus.done && lat < 40) begin
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk);
            #1;
            lat++;
            if (!bus.busy) busy_ok = 1'b0;
        end
        check("stream1_latency", lat, 32'd33);
        check("stream1_result", bus.result, 32'd100);
        bus.a = 32'd777;
        bus.b = 32'd7;
        lat   = 0;
        while ((lat == 0 || !bus.done) && lat < 40) begin
            @(posedge clk);
            #1;
            if (lat == 0) bus.start = 1'b0;
            lat++;
            if (!bus.busy) busy_ok = 1'b0;
        end
        check("stream2_latency", lat, 32'd34);
        check("stream2_result", bus.result, 32'd111);
        check("stream_busy", 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1;
        check("stream_idle", 32'(bus.busy), 32'd0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(DIVU, 32'd9, 32'd3);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            rop = div_op_type'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = $urandom_range(1, 300);
                4:       rb = 32'(0) - 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            run_op(rop, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
